// File: rtl/pe_weight_loader.sv
// Streams weight row-slices into the shadow chains of a ROWS x COLS PE array and,
// once swap_ok is seen, launches a column-skewed shift_en wavefront into the active registers.
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

module pe_weight_loader #(
   parameter int WIDTH_DATA = `WIDTH_DATA,
   parameter int ROWS       = 4,
   parameter int COLS       = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [COLS*WIDTH_DATA-1:0] in_data,
   input  logic                       swap_ok,
   output logic                       load_en,
   output logic [COLS*WIDTH_DATA-1:0] w_col,
   output logic [COLS-1:0]            shift_en,
   output logic                       tile_full,
   output logic                       swap_done
);

   // Cycles after the swap decision until loading may resume without
   // disturbing a shadow register that the wavefront has not yet captured.
   localparam int GUARD_LEN = ROWS + COLS - 3;
   localparam int BW        = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int GW        = $clog2(ROWS + COLS + 1);

   typedef enum logic [1:0] {
      LOAD       = 2'd0,
      FULL       = 2'd1,
      SWAP_GUARD = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [BW-1:0]   beat_cnt, beat_cnt_nxt;
   logic [GW-1:0]   guard_cnt, guard_cnt_nxt;
   logic [COLS-1:0] shift_q, shift_nxt;
   logic            swap_done_nxt;
   logic            accept;

   assign in_ready  = (state == LOAD);
   assign tile_full = (state == FULL);
   assign accept    = in_valid && in_ready;
   assign shift_en  = shift_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LOAD;
         beat_cnt  <= '0;
         guard_cnt <= '0;
         shift_q   <= '0;
         swap_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         beat_cnt  <= beat_cnt_nxt;
         guard_cnt <= guard_cnt_nxt;
         shift_q   <= shift_nxt;
         swap_done <= swap_done_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      beat_cnt_nxt  = beat_cnt;
      guard_cnt_nxt = guard_cnt;
      shift_nxt     = shift_q << 1;
      swap_done_nxt = 1'b0;
      case (state)
         LOAD: begin
            if (accept) begin
               if (beat_cnt == BW'(ROWS - 1)) begin
                  beat_cnt_nxt = '0;
                  state_nxt    = FULL;
               end else begin
                  beat_cnt_nxt = beat_cnt + 1'b1;
               end
            end
         end
         FULL: begin
            if (swap_ok) begin
               shift_nxt = COLS'(1);
               // Short guards end within one cycle of the decision, so the done
               // pulse is scheduled here rather than from the guard counter.
               swap_done_nxt = (GUARD_LEN <= 1);
               if (GUARD_LEN <= 0) begin
                  state_nxt     = LOAD;
                  guard_cnt_nxt = '0;
               end else begin
                  state_nxt     = SWAP_GUARD;
                  guard_cnt_nxt = GW'(1);
               end
            end
         end
         SWAP_GUARD: begin
            if (guard_cnt == GW'(GUARD_LEN)) begin
               state_nxt     = LOAD;
               guard_cnt_nxt = '0;
            end else begin
               guard_cnt_nxt = guard_cnt + 1'b1;
               swap_done_nxt = (guard_cnt == GW'(GUARD_LEN - 1));
            end
         end
         default: begin
            state_nxt = LOAD;
         end
      endcase
   end

   // Registered load path: one cycle from accepting edge to load_en/w_col.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_en <= 1'b0;
         w_col   <= '0;
      end else begin
         load_en <= accept;
         if (accept) begin
            w_col <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_pe_weight_loader.sv
// Bench for pe_weight_loader: drives tiles with random data/bubbles and checks timing
// against spec rules and against a behavioural PE array fed by the loader outputs.
module tb_pe_weight_loader;
   localparam int DW = 8;
   localparam int R  = 4;
   localparam int C  = 4;
   localparam int GL = R + C - 3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            swap_ok = 1'b0;
   logic [C*DW-1:0] in_data = '0;
   logic            in_ready, load_en, tile_full, swap_done;
   logic [C*DW-1:0] w_col;
   logic [C-1:0]    shift_en;

   int n_checks = 0;
   int n_fail   = 0;

   logic [C*DW-1:0] tile [R];
   logic [C*DW-1:0] loaded [R];
   logic [C*DW-1:0] swapped [R];
   logic [C*DW-1:0] w_col_exp = '0;

   // Reference PE array: shadow chains shift on load_en, shift_en ripples down one row per cycle.
   logic [DW-1:0] s_m [R][C];
   logic [DW-1:0] w_m [R][C];
   logic          sh_m [R][C];

   pe_weight_loader #(.WIDTH_DATA(DW), .ROWS(R), .COLS(C)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .swap_ok(swap_ok), .load_en(load_en), .w_col(w_col), .shift_en(shift_en),
      .tile_full(tile_full), .swap_done(swap_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
               s_m[r][c]  <= '0;
               w_m[r][c]  <= '0;
               sh_m[r][c] <= 1'b0;
            end
      end else begin
         for (int c = 0; c < C; c++) begin
            if (load_en) s_m[0][c] <= w_col[c*DW +: DW];
            sh_m[0][c] <= shift_en[c];
            if (shift_en[c]) w_m[0][c] <= s_m[0][c];
         end
         for (int r = 1; r < R; r++)
            for (int c = 0; c < C; c++) begin
               if (load_en) s_m[r][c] <= s_m[r-1][c];
               sh_m[r][c] <= sh_m[r-1][c];
               if (sh_m[r-1][c]) w_m[r][c] <= s_m[r][c];
            end
      end
   end

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rand_tile;
      for (int i = 0; i < R; i++) tile[i] = $urandom;
   endtask

   // mode 0: valid held high, 1: pattern 1,0,0,1,1,0,1, 2: random bubbles
   task automatic load_tile(input int mode, input int nbeats, input string tag);
      int       acc = 0;
      int       cyc = 0;
      bit       acc_prev = 1'b0;
      bit       v;
      bit [6:0] pat = 7'b1011001;
      while (1) begin
         n_checks++;
         if (load_en !== acc_prev) begin
            n_fail++;
            $display("FAIL %s load_en cyc %0d: got %b want %b", tag, cyc, load_en, acc_prev);
         end
         n_checks++;
         if (w_col !== w_col_exp) begin
            n_fail++;
            $display("FAIL %s w_col cyc %0d: got %h want %h", tag, cyc, w_col, w_col_exp);
         end
         n_checks++;
         if (in_ready !== (acc < R)) begin
            n_fail++;
            $display("FAIL %s in_ready cyc %0d: got %b want %b", tag, cyc, in_ready, (acc < R));
         end
         n_checks++;
         if (tile_full !== (acc == R)) begin
            n_fail++;
            $display("FAIL %s tile_full cyc %0d: got %b want %b", tag, cyc, tile_full, (acc == R));
         end
         n_checks++;
         if (shift_en !== '0 || swap_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_swap cyc %0d: shift_en %b swap_done %b want 0", tag, cyc, shift_en, swap_done);
         end
         if (acc == nbeats) break;
         if (cyc >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: %0d beats accepted, want %0d", tag, acc, nbeats);
            break;
         end
         case (mode)
            0:       v = 1'b1;
            1:       v = pat[cyc % 7];
            default: v = 1'($urandom_range(0, 1));
         endcase
         in_valid = v;
         in_data  = v ? tile[acc] : $urandom;
         acc_prev = v;
         if (v) begin
            w_col_exp = tile[acc];
            acc++;
         end
         step;
         in_valid = 1'b0;
         cyc++;
      end
      if (acc == R) loaded = tile;
   endtask

   // Entered in the first FULL cycle; leaves at the first cycle in_ready is due high.
   task automatic do_swap(input int hold, input bit keep_ok, input string tag);
      logic [C-1:0] exp_sh;
      for (int i = 0; i < hold; i++) begin
         swap_ok  = 1'b0;
         in_valid = 1'b1;
         in_data  = $urandom;
         step;
         in_valid = 1'b0;
         n_checks++;
         if (tile_full !== 1'b1 || in_ready !== 1'b0 || load_en !== 1'b0 || shift_en !== '0
             || swap_done !== 1'b0 || w_col !== w_col_exp) begin
            n_fail++;
            $display("FAIL %s hold %0d: full %b rdy %b ld %b sh %b done %b w_col %h want 1 0 0 0 0 %h",
                     tag, i, tile_full, in_ready, load_en, shift_en, swap_done, w_col, w_col_exp);
         end
      end
      swap_ok  = 1'b1;
      in_valid = 1'b0;
      swapped  = loaded;
      step;
      if (!keep_ok) swap_ok = 1'b0;
      for (int k = 1; k <= R + C - 2; k++) begin
         exp_sh = (k <= C) ? (C'(1) << (k - 1)) : '0;
         n_checks++;
         if (shift_en !== exp_sh) begin
            n_fail++;
            $display("FAIL %s shift_en S+%0d: got %b want %b", tag, k, shift_en, exp_sh);
         end
         n_checks++;
         if (swap_done !== (k == GL)) begin
            n_fail++;
            $display("FAIL %s swap_done S+%0d: got %b want %b", tag, k, swap_done, (k == GL));
         end
         n_checks++;
         if (in_ready !== (k == R + C - 2) || tile_full !== 1'b0 || load_en !== 1'b0) begin
            n_fail++;
            $display("FAIL %s guard S+%0d: rdy %b full %b ld %b want %b 0 0", tag, k,
                     in_ready, tile_full, load_en, (k == R + C - 2));
         end
         if (k < R + C - 2) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            step;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic check_weights(input string tag);
      logic [DW-1:0] exp_w;
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++) begin
            exp_w = swapped[R-1-r][c*DW +: DW];
            n_checks++;
            if (w_m[r][c] !== exp_w) begin
               n_fail++;
               $display("FAIL %s w_reg(%0d,%0d): got %h want %h", tag, r, c, w_m[r][c], exp_w);
            end
         end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (load_en !== 1'b0 || w_col !== '0 || shift_en !== '0 || tile_full !== 1'b0 || swap_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: ld %b w_col %h sh %b full %b done %b want all 0",
                  load_en, w_col, shift_en, tile_full, swap_done);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step;
      n_checks++;
      if (in_ready !== 1'b1 || load_en !== 1'b0 || tile_full !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: rdy %b ld %b full %b want 1 0 0", in_ready, load_en, tile_full);
      end
   endtask

   task automatic test_load;
      tile[0] = 32'h04030201;
      tile[1] = 32'h14131211;
      tile[2] = 32'h24232221;
      tile[3] = 32'h34333231;
      load_tile(0, R, "load");
   endtask

   task automatic test_swap_hold;
      do_swap(10, 1'b0, "swap_hold");
   endtask

   task automatic test_pe_array;
      step;
      step;
      check_weights("pe_array");
      n_checks++;
      if (w_m[0][0] !== 8'h31 || w_m[R-1][C-1] !== 8'h04) begin
         n_fail++;
         $display("FAIL pe_corners: PE(0,0) %h PE(3,3) %h want 31 04", w_m[0][0], w_m[R-1][C-1]);
      end
   endtask

   task automatic test_valid_bubbles;
      rand_tile;
      load_tile(1, R, "bubbles");
      do_swap(0, 1'b0, "bubbles_swap");
      step;
      step;
      check_weights("bubbles_pe");
   endtask

   task automatic test_back_to_back;
      rand_tile;
      load_tile(2, R, "tile_a");
      do_swap($urandom_range(0, 3), 1'b0, "swap_a");
      rand_tile;
      load_tile(0, R, "tile_b_immediate");
      check_weights("old_tile_a");
      swap_ok = 1'b1;
      do_swap(0, 1'b1, "b2b_swap_b");
      rand_tile;
      load_tile(2, R, "tile_c_ok_high");
      check_weights("b2b_tile_b");
      do_swap(0, 1'b1, "b2b_swap_c");
      swap_ok = 1'b0;
      step;
      step;
      check_weights("b2b_tile_c");
   endtask

   task automatic test_reset_mid_tile;
      rand_tile;
      load_tile(0, 2, "partial");
      rst_n = 1'b0;
      #1;
      w_col_exp = '0;
      n_checks++;
      if (load_en !== 1'b0 || w_col !== '0 || shift_en !== '0 || tile_full !== 1'b0
          || swap_done !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset: ld %b w_col %h sh %b full %b done %b rdy %b want 0 0 0 0 0 1",
                  load_en, w_col, shift_en, tile_full, swap_done, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step;
      n_checks++;
      if (in_ready !== 1'b1 || load_en !== 1'b0 || tile_full !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_release: rdy %b ld %b full %b want 1 0 0", in_ready, load_en, tile_full);
      end
      rand_tile;
      load_tile(2, R, "fresh");
      do_swap(1, 1'b0, "fresh_swap");
      step;
      step;
      check_weights("fresh_pe");
   endtask

   initial begin
      test_reset;
      test_load;
      test_swap_hold;
      test_pe_array;
      test_valid_bubbles;
      test_back_to_back;
      test_reset_mid_tile;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
